i2c_line_cond: RTL
==================

// Module: i2c_line_cond
// PURPOSE
//  Input conditioner between the open-drain I2C pads (SCL/SDA read-back) and the I2C controller.
//  - Synchronises both raw lines into clk and suppresses glitches.
//  - Produces clean line levels, SCL edge strobes, START/STOP detection and a bus-busy flag.
//  - The controller and bus monitor use these outputs instead of the raw pad inputs.
// PARAMETERS
//  FILT_CNT   8          consecutive stable cycles required to accept a new line level (>=2; 64 ns @125 MHz)
//  CNT_W      4          filter counter width; must hold FILT_CNT
//  STUCK_CYC  3125000    SCL-low cycles before bus_stuck asserts (25 ms @125 MHz); used only with I2C_STUCK_DET_EN
//  STUCK_W    22         stuck counter width; must hold STUCK_CYC
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous reset, active-high
//  scl_in     in   1  raw SCL pad level (asynchronous)
//  sda_in     in   1  raw SDA pad level (asynchronous)
//  scl_f      out  1  filtered SCL level
//  sda_f      out  1  filtered SDA level
//  scl_rise   out  1  1-cycle pulse on scl_f 0->1
//  scl_fall   out  1  1-cycle pulse on scl_f 1->0
//  start_det  out  1  1-cycle pulse on START or repeated START
//  stop_det   out  1  1-cycle pulse on STOP
//  bus_busy   out  1  high from START until STOP
//  bus_stuck  out  1  SCL held low too long; constant 0 when the feature is compiled out
// BEHAVIOUR
//  - Reset: sync flops, scl_f and sda_f = 1 (idle bus); all pulses, bus_busy and bus_stuck = 0; all counters = 0.
//  - Sync: two flip-flops per line. The first stage resets to 1.
//  - Filter (per line, independent):
//    - synced == filtered: counter clears to 0.
//    - otherwise counter increments.
//    - In the cycle the counter reaches FILT_CNT-1 with the mismatch still present: filtered <= synced, counter <= 0.
//    - Net effect: a level must be stable FILT_CNT cycles; shorter pulses never reach the outputs.
//    - Latency from a clean pad edge to the filtered output is 2+FILT_CNT cycles.
//  - Edge strobes: registered; high in exactly the first cycle the filtered level shows its new value.
//  - START: sda_f 1->0 while scl_f is 1 in both the previous and current cycle.
//  - STOP: sda_f 0->1 while scl_f is 1 in both the previous and current cycle.
//  - Both pulses align with the sda_f change cycle.
//  - Simultaneous scl_f and sda_f change in the same cycle: neither START nor STOP; only the SCL edge strobe fires.
//  - bus_busy: set on start_det, cleared on stop_det.
//    - Repeated START while busy: start_det pulses, bus_busy stays 1.
//    - STOP while idle: stop_det pulses, bus_busy stays 0.
//  - Reset mid-transfer: all outputs return to reset values on the next edge. No START/STOP is reported for the reset release.
// CONFIGURATION
//  - I2C_STUCK_DET_EN defined:
//    - Stuck counter increments while scl_f == 0 and saturates at STUCK_CYC.
//    - bus_stuck = 1 once the count reaches STUCK_CYC.
//    - On scl_f == 1: counter clears and bus_stuck clears in the same cycle.
//    - bus_stuck does not alter bus_busy.
//  - I2C_STUCK_DET_EN undefined: no counter logic; bus_stuck tied to 0. The port always exists.
// TESTING
//  1. Assert rst for 3 cycles with scl_in = 0, sda_in = 0 -> scl_f = sda_f = 1; all other outputs 0.
//  2. FILT_CNT=8, scl_in low pulse of 5 cycles -> scl_f stays 1; no scl_fall.
//  3. scl_in low and held -> scl_f falls exactly 10 cycles after the pad edge; scl_fall pulses high for exactly 1 cycle.
//  4. SCL=1, SDA 1->0, then SCL 1->0 20 cycles later -> start_det once; bus_busy = 1.
//     Then SCL=1, SDA 0->1 -> stop_det once; bus_busy = 0.
//  5. scl_in and sda_in both fall in the same cycle -> scl_fall pulses; start_det stays 0.
//     Reset asserted while bus_busy = 1 -> bus_busy = 0 next cycle.
//  6. With I2C_STUCK_DET_EN and STUCK_CYC=100: hold scl_f low -> bus_stuck = 1 after 100 cycles.
//     Release SCL -> bus_stuck = 0 in the cycle scl_f = 1. Without the macro, bus_stuck stays 0.

Source files
------------

// File: rtl/i2c_line_cond.sv
// I2C pad input conditioner: 2-flop sync, per-line glitch filter, SCL edge strobes, START/STOP, busy flag.
// Optional SCL-stuck-low detector is compiled in when I2C_STUCK_DET_EN is defined.
module i2c_line_cond #(
    parameter int FILT_CNT  = 8,
    parameter int CNT_W     = 4,
    parameter int STUCK_CYC = 3125000,
    parameter int STUCK_W   = 22
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_f,
    output logic sda_f,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy,
    output logic bus_stuck
);

    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILT_CNT - 1);

    generate
        if (FILT_CNT < 2 || FILT_CNT > (2 ** CNT_W) - 1 ||
            STUCK_CYC < 1 || STUCK_CYC > (2 ** STUCK_W) - 1) begin : g_param_check
            $error("i2c_line_cond: CNT_W/STUCK_W too narrow for FILT_CNT/STUCK_CYC");
        end
    endgenerate

    // Bit 0 carries SCL, bit 1 carries SDA through every stage.
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       filt;
    logic [CNT_W-1:0] cnt_q [2];
    logic [1:0]       upd;
    logic             start_nxt;
    logic             stop_nxt;

    // upd marks the cycle in which a filtered level flips on the next edge.
    always_comb begin
        upd = 2'b00;
        for (int i = 0; i < 2; i++) begin
            upd[i] = (sync2[i] != filt[i]) && (cnt_q[i] == FILT_LAST);
        end
        start_nxt = upd[1] &&  filt[1] && filt[0] && !upd[0];
        stop_nxt  = upd[1] && !filt[1] && filt[0] && !upd[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 2'b11;
            sync2     <= 2'b11;
            filt      <= 2'b11;
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            bus_busy  <= 1'b0;
        end else begin
            sync1 <= {sda_in, scl_in};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt_q[i] <= '0;
                end else if (upd[i]) begin
                    filt[i]  <= sync2[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
            scl_rise  <= upd[0] && !filt[0];
            scl_fall  <= upd[0] &&  filt[0];
            start_det <= start_nxt;
            stop_det  <= stop_nxt;
            if (start_nxt) begin
                bus_busy <= 1'b1;
            end else if (stop_nxt) begin
                bus_busy <= 1'b0;
            end
        end
    end

    assign scl_f = filt[0];
    assign sda_f = filt[1];

`ifdef I2C_STUCK_DET_EN
    localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_CYC);

    logic [STUCK_W-1:0] stuck_cnt;

    always_ff @(posedge clk) begin
        if (rst || filt[0]) begin
            stuck_cnt <= '0;
        end else if (stuck_cnt != STUCK_MAX) begin
            stuck_cnt <= stuck_cnt + 1'b1;
        end
    end

    // Gated by scl_f so the flag drops in the same cycle SCL is seen high.
    assign bus_stuck = !filt[0] && (stuck_cnt == STUCK_MAX);
`else
    assign bus_stuck = 1'b0;
`endif

endmodule
